// File: rtl/level_pkg.sv
// level_pkg: shared state type, tile widths, default tile codes and a
// lowest-set-bit encoder for the level controller.
package level_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESTORE = 3'd1,
        PLAY    = 3'd2,
        WON     = 3'd3,
        LOST    = 3'd4
    } level_state_t;

    localparam int TILE_X_W = 5;
    localparam int TILE_Y_W = 4;
    localparam logic [7:0] SKY_CODE = 8'd1;
    localparam logic [7:0] TKN_CODE = 8'd4;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest_set = 3'(i);
    endfunction
endpackage

// File: rtl/level_if.sv
// level_if: control inputs and tile-write/status outputs of the level controller.
interface level_if #(parameter int NUM_COINS = 3);
    import level_pkg::*;
    localparam int CW = $clog2(NUM_COINS + 1);
    logic                 start;
    logic [NUM_COINS-1:0] touch;
    logic                 enemy_hit;
    logic                 tile_we;
    logic [TILE_X_W-1:0]  tile_x;
    logic [TILE_Y_W-1:0]  tile_y;
    logic [7:0]           tile_code;
    logic [CW-1:0]        coins_left;
    logic [7:0]           seconds_left;
    level_state_t         state;
    logic                 win;
    logic                 lose;

    modport master (
        input  start, touch, enemy_hit,
        output tile_we, tile_x, tile_y, tile_code, coins_left, seconds_left, state, win, lose
    );
    modport slave (
        output start, touch, enemy_hit,
        input  tile_we, tile_x, tile_y, tile_code, coins_left, seconds_left, state, win, lose
    );
endinterface

// File: rtl/level_timer.sv
// level_timer: per-second prescaler and seconds down-counter; expire_o flags
// the edge on which seconds_o steps from 1 to 0.
module level_timer #(
    parameter int TIME_LIMIT        = 60,
    parameter int CLOCKS_PER_SECOND = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_i,
    input  logic       load_i,
    output logic [7:0] seconds_o,
    output logic       expire_o
);
    localparam int PW = $clog2(CLOCKS_PER_SECOND);
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    sec_q, sec_d;
    logic          wrap;

    always_comb begin
        wrap     = run_i && pre_q == PW'(CLOCKS_PER_SECOND - 1);
        pre_d    = load_i ? '0 : run_i ? (wrap ? '0 : pre_q + 1'b1) : pre_q;
        sec_d    = load_i ? 8'(TIME_LIMIT) : wrap ? sec_q - 8'd1 : sec_q;
        expire_o = !load_i && wrap && sec_q == 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            sec_q <= 8'(TIME_LIMIT);
        end else begin
            pre_q <= pre_d;
            sec_q <= sec_d;
        end
    end

    assign seconds_o = sec_q;
endmodule

// File: rtl/level_controller.sv
// level_controller: coin bookkeeping, serialised tile-map writes, level
// countdown and the IDLE/RESTORE/PLAY/WON/LOST state machine.
module level_controller import level_pkg::*; #(
    parameter int                     NUM_COINS         = 3,
    parameter logic [5*NUM_COINS-1:0] COIN_X            = {5'd9, 5'd15, 5'd2},
    parameter logic [4*NUM_COINS-1:0] COIN_Y            = {4'd2, 4'd2, 4'd5},
    parameter int                     TIME_LIMIT        = 60,
    parameter int                     CLOCKS_PER_SECOND = 25_000_000,
    parameter logic [7:0]             SKY               = SKY_CODE,
    parameter logic [7:0]             TKN               = TKN_CODE
) (
    input  logic     vga_clock,
    input  logic     reset,
    level_if.master  bus
);
    localparam int CW = $clog2(NUM_COINS + 1);

    level_state_t         state_q, state_d;
    logic [NUM_COINS-1:0] collected_q, collected_d, pending_q, pending_d, capture;
    logic [CW-1:0]        coins_q, coins_d;
    logic [2:0]           idx_q, idx_d, sel;
    logic                 we_q, we_d, expire;
    logic [4:0]           x_q, x_d;
    logic [3:0]           y_q, y_d;
    logic [7:0]           code_q, code_d;

    level_timer #(
        .TIME_LIMIT(TIME_LIMIT),
        .CLOCKS_PER_SECOND(CLOCKS_PER_SECOND)
    ) u_timer (
        .clk(vga_clock),
        .rst(reset),
        .run_i(state_q == PLAY),
        .load_i(bus.start),
        .seconds_o(bus.seconds_left),
        .expire_o(expire)
    );

    always_comb begin
        state_d     = state_q;
        collected_d = collected_q;
        pending_d   = pending_q;
        coins_d     = coins_q;
        idx_d       = idx_q;
        we_d        = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        code_d      = code_q;
        capture     = bus.touch & ~collected_q;
        sel         = lowest_set(8'(pending_q));
        if (bus.start) begin
            state_d     = RESTORE;
            collected_d = '0;
            pending_d   = '0;
            coins_d     = CW'(NUM_COINS);
            idx_d       = '0;
        end else if (state_q == RESTORE) begin
            we_d    = 1'b1;
            x_d     = COIN_X[5*idx_q +: 5];
            y_d     = COIN_Y[4*idx_q +: 4];
            code_d  = TKN;
            idx_d   = idx_q + 3'd1;
            state_d = idx_q == 3'(NUM_COINS - 1) ? PLAY : RESTORE;
        end else if (state_q == PLAY) begin
            // Newly captured coins only become issuable next cycle, so the
            // issuing coin and fresh captures never collide.
            collected_d = collected_q | bus.touch;
            pending_d   = (pending_q & ~(NUM_COINS'(1) << sel)) | capture;
            if (|pending_q) begin
                we_d    = 1'b1;
                x_d     = COIN_X[5*sel +: 5];
                y_d     = COIN_Y[4*sel +: 4];
                code_d  = SKY;
                coins_d = coins_q - 1'b1;
                state_d = coins_q == CW'(1) ? WON : PLAY;
            end
            if (bus.enemy_hit || expire) state_d = LOST;
            if (state_d != PLAY) pending_d = '0;
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            collected_q <= '0;
            pending_q   <= '0;
            coins_q     <= CW'(NUM_COINS);
            idx_q       <= '0;
            we_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            collected_q <= collected_d;
            pending_q   <= pending_d;
            coins_q     <= coins_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            x_q         <= x_d;
            y_q         <= y_d;
            code_q      <= code_d;
        end
    end

    assign bus.tile_we    = we_q;
    assign bus.tile_x     = x_q;
    assign bus.tile_y     = y_q;
    assign bus.tile_code  = code_q;
    assign bus.coins_left = coins_q;
    assign bus.state      = state_q;
    assign bus.win        = state_q == WON;
    assign bus.lose       = state_q == LOST;
endmodule

// File: tb/tb_level_controller.sv
// tb_level_controller: directed scenarios plus randomized touch/enemy traffic
// checked against a coin-set model of the level controller.
module tb_level_controller;
    import level_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int cx[3] = '{2, 15, 9};
    int cy[3] = '{5, 2, 2};

    level_if #(.NUM_COINS(3)) a_if ();
    level_if #(.NUM_COINS(3)) b_if ();

    level_controller u_a (.vga_clock(clk), .reset(rst), .bus(a_if.master));
    level_controller #(.TIME_LIMIT(3), .CLOCKS_PER_SECOND(4)) u_b (
        .vga_clock(clk), .reset(rst), .bus(b_if.master));

    always #5 clk = ~clk;

    // Model of unit A: coin sets and the write it should present after each edge.
    level_state_t m_state = IDLE;
    bit m_col[3];
    bit m_pend[3];
    bit m_we = 0;
    int m_coins = 3, m_ridx = 0, m_x = 0, m_y = 0, m_code = 0;

    task automatic model_a();
        int iss;
        bit newp[3];
        iss = -1;
        newp = '{default: 0};
        m_we = 0;
        if (rst) begin
            m_state = IDLE; m_col = '{default: 0}; m_pend = '{default: 0};
            m_coins = 3; m_x = 0; m_y = 0; m_code = 0;
            return;
        end
        if (a_if.start) begin
            m_state = RESTORE; m_col = '{default: 0}; m_pend = '{default: 0};
            m_coins = 3; m_ridx = 0;
            return;
        end
        if (m_state == RESTORE) begin
            m_we = 1; m_x = cx[m_ridx]; m_y = cy[m_ridx]; m_code = 4;
            m_ridx++;
            if (m_ridx == 3) m_state = PLAY;
        end else if (m_state == PLAY) begin
            for (int i = 2; i >= 0; i--) if (m_pend[i]) iss = i;
            for (int i = 0; i < 3; i++)
                if (a_if.touch[i] && !m_col[i]) begin m_col[i] = 1; newp[i] = 1; end
            if (iss >= 0) begin
                m_we = 1; m_x = cx[iss]; m_y = cy[iss]; m_code = 1;
                m_pend[iss] = 0; m_coins--;
                if (m_coins == 0) m_state = WON;
            end
            for (int i = 0; i < 3; i++) if (newp[i]) m_pend[i] = 1;
            if (a_if.enemy_hit) m_state = LOST;
            if (m_state != PLAY) m_pend = '{default: 0};
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_a();
        #1;
    endtask

    task automatic do_start();
        a_if.start = 1'b1;
        cyc();
        a_if.start = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({a_if.state, a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code} !== {IDLE, 1'b0, 5'd0, 4'd0, 8'd0}) begin
            n_bad++; $display("FAIL reset_outputs: got state=%0d we=%b x=%0d y=%0d code=%0d want 0 0 0 0 0",
                a_if.state, a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code);
        end
        n_cmp++;
        if ({a_if.coins_left, a_if.seconds_left, a_if.win, a_if.lose} !== {2'd3, 8'd60, 2'b00}) begin
            n_bad++; $display("FAIL reset_counts: got coins=%0d sec=%0d win=%b lose=%b want 3 60 0 0",
                a_if.coins_left, a_if.seconds_left, a_if.win, a_if.lose);
        end
        n_cmp++;
        if ({b_if.state, b_if.seconds_left} !== {IDLE, 8'd3}) begin
            n_bad++; $display("FAIL reset_b: got state=%0d sec=%0d want 0 3", b_if.state, b_if.seconds_left);
        end
        rst = 1'b0;
        do_start();
        a_if.touch = 3'b001;
        cyc();
        a_if.touch = 3'b000;
        cyc();
        #2 rst = 1'b1;
        #1 model_a();
        n_cmp++;
        if ({a_if.state, a_if.coins_left, a_if.seconds_left, a_if.tile_we} !== {IDLE, 2'd3, 8'd60, 1'b0}) begin
            n_bad++; $display("FAIL reset_mid_play: got state=%0d coins=%0d sec=%0d we=%b want 0 3 60 0",
                a_if.state, a_if.coins_left, a_if.seconds_left, a_if.tile_we);
        end
        cyc();
        rst = 1'b0;
        a_if.touch = 3'b111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if ({a_if.state, a_if.tile_we, a_if.coins_left} !== {IDLE, 1'b0, 2'd3}) begin
                n_bad++; $display("FAIL idle_ignores_touch: got state=%0d we=%b coins=%0d want 0 0 3",
                    a_if.state, a_if.tile_we, a_if.coins_left);
            end
        end
        a_if.touch = 3'b000;
    endtask

    task automatic test_restore();
        a_if.start = 1'b1;
        cyc();
        a_if.start = 1'b0;
        n_cmp++;
        if ({a_if.state, a_if.tile_we} !== {RESTORE, 1'b0}) begin
            n_bad++; $display("FAIL restore_entry: got state=%0d we=%b want 1 0", a_if.state, a_if.tile_we);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if ({a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code, a_if.state} !==
                {1'b1, 5'(cx[i]), 4'(cy[i]), 8'd4, (i == 2) ? PLAY : RESTORE}) begin
                n_bad++; $display("FAIL restore_write%0d: got we=%b x=%0d y=%0d code=%0d state=%0d want 1 %0d %0d 4 %0d",
                    i, a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code, a_if.state, cx[i], cy[i], (i == 2) ? 2 : 1);
            end
        end
        cyc();
        n_cmp++;
        if ({a_if.tile_we, a_if.tile_x, a_if.tile_code} !== {1'b0, 5'd9, 8'd4}) begin
            n_bad++; $display("FAIL restore_hold: got we=%b x=%0d code=%0d want 0 9 4", a_if.tile_we, a_if.tile_x, a_if.tile_code);
        end
    endtask

    task automatic test_all_touch();
        do_start();
        a_if.touch = 3'b111;
        cyc();
        a_if.touch = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if ({a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code, a_if.coins_left, a_if.state, a_if.win} !==
                {1'b1, 5'(cx[k]), 4'(cy[k]), 8'd1, 2'(2 - k), (k == 2) ? WON : PLAY, k == 2}) begin
                n_bad++; $display("FAIL all_touch_write%0d: got we=%b x=%0d y=%0d code=%0d coins=%0d state=%0d win=%b want 1 %0d %0d 1 %0d %0d %0d",
                    k, a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code, a_if.coins_left, a_if.state, a_if.win,
                    cx[k], cy[k], 2 - k, (k == 2) ? 3 : 2, k == 2);
            end
        end
        a_if.touch = 3'b111;
        cyc();
        n_cmp++;
        if ({a_if.tile_we, a_if.state} !== {1'b0, WON}) begin
            n_bad++; $display("FAIL won_terminal: got we=%b state=%0d want 0 3", a_if.tile_we, a_if.state);
        end
        a_if.touch = 3'b000;
    endtask

    task automatic test_held_touch();
        int writes = 0, lx = 0, ly = 0;
        do_start();
        a_if.touch = 3'b010;
        repeat (20) begin
            cyc();
            if (a_if.tile_we) begin writes++; lx = a_if.tile_x; ly = a_if.tile_y; end
        end
        a_if.touch = 3'b000;
        n_cmp++;
        if (writes != 1 || lx != 15 || ly != 2 || a_if.coins_left !== 2'd2) begin
            n_bad++; $display("FAIL held_touch: got writes=%0d x=%0d y=%0d coins=%0d want 1 15 2 2",
                writes, lx, ly, a_if.coins_left);
        end
    endtask

    task automatic test_timer();
        int exp_sec;
        level_state_t exp_state;
        b_if.start = 1'b1;
        cyc();
        b_if.start = 1'b0;
        n_cmp++;
        if ({b_if.state, b_if.seconds_left} !== {RESTORE, 8'd3}) begin
            n_bad++; $display("FAIL timer_start: got state=%0d sec=%0d want 1 3", b_if.state, b_if.seconds_left);
        end
        repeat (3) cyc();
        for (int n = 1; n <= 18; n++) begin
            cyc();
            exp_sec = (n >= 12) ? 0 : 3 - n / 4;
            exp_state = (n >= 12) ? LOST : PLAY;
            n_cmp++;
            if ({b_if.seconds_left, b_if.state, b_if.lose} !== {8'(exp_sec), exp_state, n >= 12}) begin
                n_bad++; $display("FAIL timer_play%0d: got sec=%0d state=%0d lose=%b want %0d %0d %0d",
                    n, b_if.seconds_left, b_if.state, b_if.lose, exp_sec, exp_state, n >= 12);
            end
        end
    endtask

    task automatic test_enemy_final();
        do_start();
        a_if.touch = 3'b111;
        cyc();
        a_if.touch = 3'b000;
        repeat (2) cyc();
        a_if.enemy_hit = 1'b1;
        cyc();
        a_if.enemy_hit = 1'b0;
        n_cmp++;
        if ({a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code, a_if.coins_left, a_if.state, a_if.win, a_if.lose} !==
            {1'b1, 5'd9, 4'd2, 8'd1, 2'd0, LOST, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL final_vs_enemy: got we=%b x=%0d y=%0d code=%0d coins=%0d state=%0d win=%b lose=%b want 1 9 2 1 0 4 0 1",
                a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code, a_if.coins_left, a_if.state, a_if.win, a_if.lose);
        end
        cyc();
        n_cmp++;
        if ({a_if.tile_we, a_if.state} !== {1'b0, LOST}) begin
            n_bad++; $display("FAIL lost_terminal: got we=%b state=%0d want 0 4", a_if.tile_we, a_if.state);
        end
        a_if.start = 1'b1;
        cyc();
        a_if.start = 1'b0;
        n_cmp++;
        if ({a_if.state, a_if.coins_left, a_if.lose} !== {RESTORE, 2'd3, 1'b0}) begin
            n_bad++; $display("FAIL restart_after_lost: got state=%0d coins=%0d lose=%b want 1 3 0",
                a_if.state, a_if.coins_left, a_if.lose);
        end
        repeat (3) cyc();
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 8; ep++) begin
            do_start();
            for (int c = 0; c < 30; c++) begin
                a_if.touch = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                a_if.enemy_hit = ($urandom_range(0, 39) == 0);
                a_if.start = ($urandom_range(0, 59) == 0);
                cyc();
                n_cmp++;
                if ({a_if.state, a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code, a_if.coins_left, a_if.seconds_left,
                     a_if.win, a_if.lose} !==
                    {m_state, m_we, 5'(m_x), 4'(m_y), 8'(m_code), 2'(m_coins), 8'd60, m_state == WON, m_state == LOST}) begin
                    n_bad++; $display("FAIL random_ep%0d_c%0d: got state=%0d we=%b x=%0d y=%0d code=%0d coins=%0d sec=%0d want state=%0d we=%b x=%0d y=%0d code=%0d coins=%0d sec=60",
                        ep, c, a_if.state, a_if.tile_we, a_if.tile_x, a_if.tile_y, a_if.tile_code, a_if.coins_left,
                        a_if.seconds_left, m_state, m_we, m_x, m_y, m_code, m_coins);
                end
            end
            a_if.touch = 3'b000;
            a_if.enemy_hit = 1'b0;
            a_if.start = 1'b0;
        end
    endtask

    initial begin
        a_if.start = 1'b0; a_if.touch = 3'b000; a_if.enemy_hit = 1'b0;
        b_if.start = 1'b0; b_if.touch = 3'b000; b_if.enemy_hit = 1'b0;
        repeat (3) cyc();
        test_reset();
        test_restore();
        test_all_touch();
        test_held_touch();
        test_timer();
        test_enemy_final();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
